// File: rtl/mips_md_pkg.sv
// rtl/mips_md_pkg.sv - shared op/state encodings and data width for the multiply/divide unit
package mips_md_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIN  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - conditional two's-complement negate of an N-bit value
module md_sign_fix #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);

    assign y = neg ? (~a + N'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
module mult_div_unit
    import mips_md_pkg::*;
#(
    parameter int N = MD_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [2:0]   Op,
    input  logic [N-1:0] OperandA,
    input  logic [N-1:0] OperandB,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero,
    output logic [N-1:0] HI,
    output logic [N-1:0] LO
);

    localparam int CW = $clog2(N);

    md_state_e     state, nextState;
    logic [CW-1:0] count;
    logic [N:0]    accReg;
    logic [N-1:0]  shReg;
    logic [N-1:0]  opnd;
    logic          isMultReg, divZeroReg, negHi, negLo;

    logic          isMultOp, isDivOp, signedOp, startMd, divZero;
    logic [N-1:0]  magA, magB, hiRaw, hiFixed, loFixed;
    logic [N:0]    addSum, mulSum, divShift;
    logic          divGeq;

    assign isMultOp = (Op == MD_MULT) || (Op == MD_MULTU);
    assign isDivOp  = (Op == MD_DIV)  || (Op == MD_DIVU);
    assign signedOp = (Op == MD_MULT) || (Op == MD_DIV);
    assign startMd  = Start && (state == MD_IDLE) && (isMultOp || isDivOp);
    assign divZero  = isDivOp && (OperandB == '0);
    assign Busy     = (state != MD_IDLE);

    md_sign_fix #(.N(N)) uFixA  (.neg(signedOp & OperandA[N-1]), .a(OperandA), .y(magA));
    md_sign_fix #(.N(N)) uFixB  (.neg(signedOp & OperandB[N-1]), .a(OperandB), .y(magB));

    // Negating a 2N product with N-bit negators: -{H,L} = {-(H + (L!=0)), -L}.
    assign hiRaw = accReg[N-1:0] + {{(N-1){1'b0}}, isMultReg & negLo & (|shReg)};

    md_sign_fix #(.N(N)) uFixHi (.neg(negHi), .a(hiRaw),  .y(hiFixed));
    md_sign_fix #(.N(N)) uFixLo (.neg(negLo), .a(shReg),  .y(loFixed));

    assign addSum   = accReg + {1'b0, opnd};
    assign mulSum   = shReg[0] ? addSum : accReg;
    assign divShift = {accReg[N-1:0], shReg[N-1]};
    assign divGeq   = (divShift >= {1'b0, opnd});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            MD_IDLE: if (startMd) nextState = divZero ? MD_FIN : MD_RUN;
            MD_RUN:  if (count == CW'(N-1)) nextState = MD_FIN;
            MD_FIN:  nextState = MD_IDLE;
            default: nextState = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            accReg     <= '0;
            shReg      <= '0;
            opnd       <= '0;
            isMultReg  <= 1'b0;
            divZeroReg <= 1'b0;
            negHi      <= 1'b0;
            negLo      <= 1'b0;
            HI         <= '0;
            LO         <= '0;
            Done       <= 1'b0;
            DivByZero  <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (startMd) begin
                        count      <= '0;
                        accReg     <= '0;
                        isMultReg  <= isMultOp;
                        divZeroReg <= divZero;
                        // Multiply adds the multiplicand; divide subtracts the divisor.
                        opnd       <= isMultOp ? magA : magB;
                        shReg      <= isMultOp ? magB : magA;
                        negLo      <= signedOp & (OperandA[N-1] ^ OperandB[N-1]);
                        negHi      <= isMultOp ? signedOp & (OperandA[N-1] ^ OperandB[N-1])
                                               : signedOp & OperandA[N-1];
                    end else if (Start && Op == MD_MTHI) begin
                        HI <= OperandA;
                    end else if (Start && Op == MD_MTLO) begin
                        LO <= OperandA;
                    end
                end
                MD_RUN: begin
                    count <= count + CW'(1);
                    if (isMultReg) begin
                        accReg <= {1'b0, mulSum[N:1]};
                        shReg  <= {mulSum[0], shReg[N-1:1]};
                    end else begin
                        accReg <= divGeq ? (divShift - {1'b0, opnd}) : divShift;
                        shReg  <= {shReg[N-2:0], divGeq};
                    end
                end
                MD_FIN: begin
                    Done <= 1'b1;
                    if (divZeroReg) begin
                        DivByZero <= 1'b1;
                    end else begin
                        HI <= hiFixed;
                        LO <= loFixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
